// File: rtl/uart_tx_ctrl_if.sv
// Handshake/bus bundle for uart_tx_ctrl.
// master: frame requester plus serializer side. slave: the controller.
interface uart_tx_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] P_DATA;
    logic             Data_Valid;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             ser_data;
    logic             ser_done;
    logic             ser_en;
    logic             busy;
    logic             TX_OUT;
    logic             ser_err;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, busy, TX_OUT, ser_err
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, busy, TX_OUT, ser_err
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start bit, WIDTH data bits (from the serializer),
// optional parity bit, stop bit(s). TX_OUT is registered one cycle behind state.
// Optional macro UART_TX_TWO_STOP_EN adds a second stop bit (STOP2 state).
module uart_tx_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic           CLK,
    input logic           RST,
    uart_tx_ctrl_if.slave tx_if
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_TWO_STOP_EN
        , STOP2
`endif
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          par_en_q;
    logic          par_bit_q;
    logic          tx_q;
    logic          err_q;
    logic          last_bit;
    logic          exit_data;
    logic          mismatch;

    // Data-phase exit conditions: serializer flag or own count, whichever first.
    always_comb begin
        last_bit  = (cnt == CW'(WIDTH - 1));
        exit_data = tx_if.ser_done | last_bit;
        mismatch  = tx_if.ser_done ^ last_bit;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tx_if.Data_Valid) state_nxt = START;
            START:   state_nxt = DATA;
            DATA:    if (exit_data) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  state_nxt = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:    state_nxt = STOP2;
            STOP2:   state_nxt = IDLE;
`else
            STOP:    state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Datapath: bit counter, parity latch, error pulse and registered line.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt       <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            err_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            if (state != DATA && state_nxt == DATA) cnt <= '0;
            else if (state == DATA)                 cnt <= cnt + CW'(1);

            if (state == IDLE && tx_if.Data_Valid) begin
                par_en_q  <= tx_if.PAR_EN;
                par_bit_q <= (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
            end

            // A mismatch can only occur on an exiting cycle, since either flag exits.
            err_q <= (state == DATA) && mismatch;

            case (state)
                IDLE:    tx_q <= 1'b1;
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= tx_if.ser_data;
                PARITY:  tx_q <= par_bit_q;
                default: tx_q <= 1'b1;
            endcase
        end
    end

    assign tx_if.ser_en  = (state == DATA);
    assign tx_if.busy    = (state != IDLE);
    assign tx_if.TX_OUT  = tx_q;
    assign tx_if.ser_err = err_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frame table, hand-written
// corner sequences, then randomized traffic against a frame-queue model.
module tb_uart_tx_ctrl;
    localparam int unsigned WIDTH = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif
    localparam int WIN = 20;

    logic clk;
    logic rst;

    uart_tx_ctrl_if #(.WIDTH(WIDTH)) tx_if ();

    uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RST   (rst),
        .tx_if (tx_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    // Serializer stand-in: loads on the accepting edge, shifts LSB first while enabled.
    logic [WIDTH-1:0] sreg;
    int               scnt;
    logic             force_done;

    always @(posedge clk) begin
        if (!rst) begin
            sreg <= '0;
            scnt <= 0;
        end else if (tx_if.Data_Valid && !tx_if.busy) begin
            sreg <= tx_if.P_DATA;
            scnt <= 0;
        end else if (tx_if.ser_en) begin
            sreg <= sreg >> 1;
            scnt <= scnt + 1;
        end
    end

    assign tx_if.ser_data = sreg[0];
    assign tx_if.ser_done = (tx_if.ser_en && scnt == WIDTH - 1) || force_done;

    // Reference model: a queue of line bits per accepted frame and a busy countdown.
    logic q[$];
    int   mleft = 0;
    int   mlen  = 0;
    logic mtx   = 1'b1;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            mleft = 0;
            mtx   = 1'b1;
        end else begin
            mtx = (q.size() > 0) ? q.pop_front() : 1'b1;
            if (mleft > 0) begin
                mleft--;
            end else if (tx_if.Data_Valid) begin
                q.push_back(1'b0);
                for (int i = 0; i < WIDTH; i++) q.push_back(tx_if.P_DATA[i]);
                if (tx_if.PAR_EN) q.push_back((^tx_if.P_DATA) ^ tx_if.PAR_TYP);
                for (int i = 0; i < STOPS; i++) q.push_back(1'b1);
                mlen  = 1 + WIDTH + int'(tx_if.PAR_EN) + STOPS;
                mleft = mlen;
            end
        end
    end

    // Directed frame table; bits listed first-on-line at the left, single stop bit.
    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        logic [10:0] bits;
        int          len;
        int          force_at;
        int          inject_at;
        int          nsen;
        int          nerr;
    } vec_t;

    vec_t vecs[7];

    logic tx_cap[WIN];
    int   busy_n;
    int   sen_n;
    int   err_n;

    // Start one frame and record WIN cycles of line/status after the accepting edge.
    task automatic run_frame(input vec_t v);
        int sc;
        sc = 0;
        busy_n = 0; sen_n = 0; err_n = 0;
        @(negedge clk);
        tx_if.P_DATA     = v.data;
        tx_if.PAR_EN     = v.pen;
        tx_if.PAR_TYP    = v.ptyp;
        tx_if.Data_Valid = 1'b1;
        @(negedge clk);
        tx_if.Data_Valid = 1'b0;
        tx_if.P_DATA     = ~v.data;
        tx_if.PAR_EN     = ~v.pen;
        tx_if.PAR_TYP    = ~v.ptyp;
        for (int n = 0; n < WIN; n++) begin
            tx_cap[n] = tx_if.TX_OUT;
            if (tx_if.busy)    busy_n++;
            if (tx_if.ser_err) err_n++;
            if (tx_if.ser_en) begin
                sen_n++;
                sc++;
            end
            force_done = (v.force_at != 0) && tx_if.ser_en && (sc == v.force_at);
            if (v.inject_at != 0 && tx_if.ser_en && sc == v.inject_at) begin
                tx_if.Data_Valid = 1'b1;
                tx_if.P_DATA     = 8'h3C;
            end else begin
                tx_if.Data_Valid = 1'b0;
            end
            @(negedge clk);
        end
        force_done = 1'b0;
    endtask

    task automatic check_frame(input vec_t v, input int idx);
        int total;
        logic b;
        total = v.len + STOPS - 1;
        chk($sformatf("v%0d idle_before", idx), int'(tx_cap[0]), 1);
        for (int i = 0; i < total; i++) begin
            b = (i < v.len) ? v.bits[v.len - 1 - i] : 1'b1;
            chk($sformatf("v%0d bit%0d", idx, i), int'(tx_cap[i + 1]), int'(b));
        end
        chk($sformatf("v%0d idle_after", idx), int'(tx_cap[total + 1]), 1);
        chk($sformatf("v%0d busy_cycles", idx), busy_n, total);
        chk($sformatf("v%0d ser_en_cycles", idx), sen_n, v.nsen);
        chk($sformatf("v%0d ser_err_cycles", idx), err_n, v.nerr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        force_done = 1'b0;
        tx_if.P_DATA = '0;
        tx_if.Data_Valid = 1'b0;
        tx_if.PAR_EN = 1'b0;
        tx_if.PAR_TYP = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, 0, 0, 8, 0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, 0, 0, 8, 0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 11'b00101001011, 10, 0, 0, 8, 0};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 11'b00011110011, 11, 0, 0, 8, 0};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 11'b01000000011, 11, 0, 0, 8, 0};
        // 0x3C request pulsed mid-DATA must be ignored.
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 11'b00111111111, 10, 0, 2, 8, 0};
        // ser_done forced on the 4th data cycle: 4 data bits, parity 0, one error pulse.
        vecs[6] = '{8'hA5, 1'b1, 1'b0, 11'b00000101001, 7, 4, 0, 4, 1};

        repeat (2) @(negedge clk);
        chk("reset tx", int'(tx_if.TX_OUT), 1);
        chk("reset busy", int'(tx_if.busy), 0);
        chk("reset ser_en", int'(tx_if.ser_en), 0);
        chk("reset ser_err", int'(tx_if.ser_err), 0);
        rst = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_frame(vecs[k]);
            check_frame(vecs[k], k);
        end

        // Reset held two edges mid-frame.
        @(negedge clk);
        tx_if.P_DATA = 8'hA5; tx_if.PAR_EN = 1'b1; tx_if.PAR_TYP = 1'b0;
        tx_if.Data_Valid = 1'b1;
        @(negedge clk);
        tx_if.Data_Valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset tx", int'(tx_if.TX_OUT), 1);
        chk("midreset busy", int'(tx_if.busy), 0);
        chk("midreset ser_en", int'(tx_if.ser_en), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset idle tx", int'(tx_if.TX_OUT), 1);
        chk("post_reset idle busy", int'(tx_if.busy), 0);

        // Back-to-back frames with Data_Valid held high.
        begin
            int f;
            int errs;
            f = 1 + WIDTH + STOPS;
            errs = 0;
            tx_if.P_DATA = 8'h00; tx_if.PAR_EN = 1'b0; tx_if.PAR_TYP = 1'b0;
            tx_if.Data_Valid = 1'b1;
            @(negedge clk);
            for (int n = 0; n < WIN; n++) begin
                tx_cap[n] = tx_if.TX_OUT;
                if (tx_if.ser_err) errs++;
                if (n == f) chk("b2b idle busy", int'(tx_if.busy), 0);
                if (n == f + 1) chk("b2b restart busy", int'(tx_if.busy), 1);
                @(negedge clk);
            end
            tx_if.Data_Valid = 1'b0;
            chk("b2b start", int'(tx_cap[1]), 0);
            chk("b2b last stop", int'(tx_cap[f]), 1);
            chk("b2b gap", int'(tx_cap[f + 1]), 1);
            chk("b2b second start", int'(tx_cap[f + 2]), 0);
            chk("b2b ser_err", errs, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int idx;
            logic exp_sen;
            idx = mlen - mleft;
            exp_sen = (mleft > 0) && (idx >= 1) && (idx <= WIDTH);
            chk($sformatf("rand%0d tx", n), int'(tx_if.TX_OUT), int'(mtx));
            chk($sformatf("rand%0d busy", n), int'(tx_if.busy), int'(mleft > 0));
            chk($sformatf("rand%0d ser_en", n), int'(tx_if.ser_en), int'(exp_sen));
            chk($sformatf("rand%0d ser_err", n), int'(tx_if.ser_err), 0);
            rst              = ($urandom_range(0, 79) != 0);
            tx_if.Data_Valid = ($urandom_range(0, 2) == 0);
            tx_if.P_DATA     = 8'($urandom);
            tx_if.PAR_EN     = 1'($urandom);
            tx_if.PAR_TYP    = 1'($urandom);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
